// File: rtl/jpeg_top_core_if.sv
// Pixel-in / bitstream-out bundle for jpeg_top_core.
// master drives pixels and EOF; slave returns the packed stream.
interface jpeg_top_core_if;
    logic        enable;
    logic [23:0] data_in;
    logic        end_of_file_signal;
    logic [31:0] JPEG_bitstream;
    logic        data_ready;
    logic [4:0]  end_of_file_bitstream_count;
    logic        eof_data_partial_ready;

    modport master (
        output enable, data_in, end_of_file_signal,
        input  JPEG_bitstream, data_ready,
        input  end_of_file_bitstream_count, eof_data_partial_ready
    );

    modport slave (
        input  enable, data_in, end_of_file_signal,
        output JPEG_bitstream, data_ready,
        output end_of_file_bitstream_count, eof_data_partial_ready
    );
endinterface

// File: rtl/jpeg_top_core.sv
// DC-only JPEG luma coder: block mean -> DPCM -> Huffman DC + EOB.
// Codes are packed MSB-first into 32-bit words with a padded EOF flush.
module jpeg_top_core (
    input  logic            clk,
    input  logic            rst,
    jpeg_top_core_if.slave  bus
);
    logic [5:0]  r_pcnt;
    logic [13:0] r_acc;
    logic [13:0] r_sum;
    logic        r_vsum;
    logic [17:0] r_code;
    logic [4:0]  r_len;
    logic        r_vcode;
    logic [7:0]  r_prev;
    logic [63:0] r_buf;
    logic [6:0]  r_bcnt;
    logic        r_eof1;
    logic        r_eof2;
    logic        r_eofp;
    logic [31:0] r_word;
    logic        r_dr;
    logic        r_pr;
    logic [4:0]  r_k;

    logic [15:0]        w_lsum;
    logic [7:0]         w_y;
    logic [13:0]        w_acc_nx;
    logic signed [11:0] w_t;
    logic [7:0]         w_dc;
    logic [8:0]         w_diff;
    logic [8:0]         w_abs;
    logic [8:0]         w_mval;
    logic [8:0]         w_mag;
    logic [3:0]         w_cat;
    logic [5:0]         w_pre;
    logic [2:0]         w_plen;
    logic [4:0]         w_len;
    logic [17:0]        w_raw;
    logic [17:0]        w_code;
    logic [63:0]        w_ins;
    logic [63:0]        w_comb;
    logic [6:0]         w_ccnt;
    logic               w_eof;
    logic               w_full;
    logic               w_flush;
    logic [31:0]        w_pad;

    assign w_lsum = 16'd77  * {8'd0, bus.data_in[7:0]}
                  + 16'd150 * {8'd0, bus.data_in[15:8]}
                  + 16'd29  * {8'd0, bus.data_in[23:16]};
    assign w_y      = w_lsum[15:8];
    assign w_acc_nx = r_acc + {6'd0, w_y};

    // DC = ((S>>3)-1024)>>>3 fits in 8 signed bits, so take t[10:3]
    assign w_t    = $signed({1'b0, r_sum[13:3]}) - 12'sd1024;
    assign w_dc   = w_t[10:3];
    assign w_diff = {w_dc[7], w_dc} - {r_prev[7], r_prev};
    assign w_abs  = w_diff[8] ? (9'd0 - w_diff) : w_diff;
    assign w_mval = w_diff[8] ? (w_diff - 9'd1) : w_diff;

    // Category, DC prefix and the left-aligned prefix|magnitude|EOB code
    always_comb begin
        w_cat  = 4'd0;
        w_pre  = 6'b000000;
        w_plen = 3'd2;
        for (int i = 0; i < 8; i++) begin
            if (w_abs[i]) w_cat = 4'(i + 1);
        end
        case (w_cat)
            4'd0:    begin w_pre = 6'b000000; w_plen = 3'd2; end
            4'd1:    begin w_pre = 6'b000010; w_plen = 3'd3; end
            4'd2:    begin w_pre = 6'b000011; w_plen = 3'd3; end
            4'd3:    begin w_pre = 6'b000100; w_plen = 3'd3; end
            4'd4:    begin w_pre = 6'b000101; w_plen = 3'd3; end
            4'd5:    begin w_pre = 6'b000110; w_plen = 3'd3; end
            4'd6:    begin w_pre = 6'b001110; w_plen = 3'd4; end
            4'd7:    begin w_pre = 6'b011110; w_plen = 3'd5; end
            default: begin w_pre = 6'b111110; w_plen = 3'd6; end
        endcase
        w_mag  = w_mval & ((9'd1 << w_cat) - 9'd1);
        w_len  = {2'd0, w_plen} + {1'b0, w_cat} + 5'd4;
        w_raw  = ({12'd0, w_pre} << w_cat) | {9'd0, w_mag};
        w_raw  = (w_raw << 4) | 18'd10;
        w_code = w_raw << (5'd18 - w_len);
    end

    assign w_ins   = r_vcode ? ({r_code, 46'd0} >> r_bcnt) : 64'd0;
    assign w_comb  = r_buf | w_ins;
    assign w_ccnt  = r_bcnt + (r_vcode ? {2'd0, r_len} : 7'd0);
    assign w_eof   = r_eof2 | r_eofp;
    assign w_full  = (w_ccnt >= 7'd32);
    assign w_flush = w_eof & ~w_full;
    assign w_pad   = 32'hFFFF_FFFF >> w_ccnt[4:0];

    // Pixel counter and luma accumulator; a full block latches its sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt <= '0;
            r_acc  <= '0;
            r_sum  <= '0;
            r_vsum <= 1'b0;
        end else if (w_flush) begin
            r_pcnt <= '0;
            r_acc  <= '0;
            r_vsum <= 1'b0;
        end else begin
            r_vsum <= 1'b0;
            if (bus.enable) begin
                r_pcnt <= r_pcnt + 6'd1;
                if (r_pcnt == 6'd63) begin
                    r_sum  <= w_acc_nx;
                    r_vsum <= 1'b1;
                    r_acc  <= '0;
                end else begin
                    r_acc <= w_acc_nx;
                end
            end
        end
    end

    // Code stage: register the block code and advance the DC predictor
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code  <= '0;
            r_len   <= '0;
            r_vcode <= 1'b0;
            r_prev  <= '0;
        end else if (w_flush) begin
            r_vcode <= 1'b0;
            r_prev  <= '0;
        end else begin
            r_vcode <= r_vsum;
            if (r_vsum) begin
                r_code <= w_code;
                r_len  <= w_len;
                r_prev <= w_dc;
            end
        end
    end

    // Packer: emit full words first, a pending EOF flushes the remainder
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf  <= '0;
            r_bcnt <= '0;
            r_eof1 <= 1'b0;
            r_eof2 <= 1'b0;
            r_eofp <= 1'b0;
            r_word <= '0;
            r_dr   <= 1'b0;
            r_pr   <= 1'b0;
            r_k    <= '0;
        end else begin
            r_eof1 <= bus.end_of_file_signal;
            r_eof2 <= r_eof1;
            r_dr   <= 1'b0;
            r_pr   <= 1'b0;
            if (w_full) begin
                r_word <= w_comb[63:32];
                r_dr   <= 1'b1;
                r_buf  <= w_comb << 32;
                r_bcnt <= w_ccnt - 7'd32;
                r_eofp <= w_eof;
            end else if (w_eof) begin
                r_word <= w_comb[63:32] | w_pad;
                r_k    <= w_ccnt[4:0];
                r_pr   <= 1'b1;
                r_buf  <= '0;
                r_bcnt <= '0;
                r_eofp <= 1'b0;
            end else begin
                r_buf  <= w_comb;
                r_bcnt <= w_ccnt;
            end
        end
    end

    assign bus.JPEG_bitstream              = r_word;
    assign bus.data_ready                  = r_dr;
    assign bus.end_of_file_bitstream_count = r_k;
    assign bus.eof_data_partial_ready      = r_pr;
endmodule

// File: tb/tb_jpeg_top_core.sv
// Scoreboard bench for jpeg_top_core: directed blocks with
// hand-computed words, checked by an independent strobe monitor.
module tb_jpeg_top_core;
    typedef struct {
        bit          part;
        logic [31:0] w;
        logic [4:0]  k;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   cyc;
    exp_t sb[$];

    jpeg_top_core_if bus ();

    jpeg_top_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout watchdog expired");
        $fatal(1);
    end

    // Monitor: pop one expectation per output strobe
    always @(negedge clk) begin
        exp_t e;
        if (rst && (bus.data_ready || bus.eof_data_partial_ready)) begin
            checks++;
            if (bus.data_ready && bus.eof_data_partial_ready) begin
                errors++;
                $display("FAIL excl: both strobes high at cycle %0d", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected strobe dr=%b pr=%b word=%h",
                         bus.data_ready, bus.eof_data_partial_ready,
                         bus.JPEG_bitstream);
            end else begin
                e = sb.pop_front();
                if (bus.eof_data_partial_ready != e.part ||
                    bus.JPEG_bitstream != e.w) begin
                    errors++;
                    $display("FAIL word: got pr=%b %h, want pr=%b %h",
                             bus.eof_data_partial_ready,
                             bus.JPEG_bitstream, e.part, e.w);
                end
                checks++;
                if (e.part) begin
                    if (bus.end_of_file_bitstream_count != e.k) begin
                        errors++;
                        $display("FAIL count: got %0d, want %0d",
                                 bus.end_of_file_bitstream_count, e.k);
                    end
                end else begin
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL word_time: got cycle %0d, want %0d",
                                 cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        checks++;
        if (bus.JPEG_bitstream !== 32'd0 || bus.data_ready !== 1'b0 ||
            bus.eof_data_partial_ready !== 1'b0 ||
            bus.end_of_file_bitstream_count !== 5'd0) begin
            errors++;
            $display("FAIL %s: got %h dr=%b pr=%b k=%0d, want all 0", tag,
                     bus.JPEG_bitstream, bus.data_ready,
                     bus.eof_data_partial_ready,
                     bus.end_of_file_bitstream_count);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic [23:0] p);
        bus.enable  = 1'b1;
        bus.data_in = p;
        step();
        bus.enable  = 1'b0;
    endtask

    task automatic block(input logic [23:0] p, input int n, input bit stall);
        for (int i = 0; i < n; i++) begin
            pixel(p);
            if (stall) step();
        end
    endtask

    task automatic eof();
        bus.end_of_file_signal = 1'b1;
        step();
        bus.end_of_file_signal = 1'b0;
        repeat (6) step();
    endtask

    task automatic exp_part(input logic [31:0] w, input logic [4:0] k);
        sb.push_back('{1'b1, w, k, -1});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b0;
        bus.enable = 1'b0;
        bus.data_in = '0;
        bus.end_of_file_signal = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        step();

        // all-black block: diff=-128, 18-bit code
        block(24'h000000, 64, 1'b0);
        exp_part(32'hF9FEBFFF, 5'd18);
        eof();

        // mid-grey block: DC=0, diff=0
        block(24'h808080, 64, 1'b0);
        exp_part(32'h2BFFFFFF, 5'd6);
        eof();

        // two black blocks: second diff=0
        block(24'h000000, 64, 1'b0);
        block(24'h000000, 64, 1'b0);
        exp_part(32'hF9FE8AFF, 5'd24);
        eof();

        // black then white: 36 bits -> one word plus 4 bits
        block(24'h000000, 64, 1'b0);
        block(24'hFFFFFF, 63, 1'b0);
        sb.push_back('{1'b0, 32'hF9FEBEFF, 5'd0, cyc + 3});
        pixel(24'hFFFFFF);
        exp_part(32'hAFFFFFFF, 5'd4);
        eof();

        // stalled black block, then incomplete block discarded
        block(24'h000000, 64, 1'b1);
        exp_part(32'hF9FEBFFF, 5'd18);
        eof();
        block(24'h000000, 40, 1'b0);
        exp_part(32'hFFFFFFFF, 5'd0);
        eof();

        // reset mid-block drops buffered bits and prev_DC
        block(24'h000000, 64, 1'b0);
        block(24'hFFFFFF, 20, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        step();
        block(24'h808080, 64, 1'b0);
        exp_part(32'h2BFFFFFF, 5'd6);
        eof();

        repeat (10) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs missing, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
